lockin_display_decimator: RTL

//  Boxcar decimator between the lock-in CORDIC output and the VGA visualizer.
//  - Averages 2^LOG2_DECIM consecutive (magnitude, phase) samples.
//  - Emits one averaged sample per window as a single-cycle o_valid pulse.
//  - Sets the display scroll rate and suppresses noise before column plotting.

---
 rtl/lockin_display_decimator_pkg.sv | 13 +
 rtl/lockin_display_decimator_if.sv | 23 ++
 rtl/lockin_boxcar_acc.sv | 53 +++++
 rtl/lockin_display_decimator.sv | 122 ++++++++++++
 4 files changed

// File: rtl/lockin_display_decimator_pkg.sv
// Shared defaults and width helper for the lock-in display decimator (package lockin_pkg).
package lockin_pkg;

    localparam int CORDIC_WIDTH_DEF = 42;
    localparam int LOG2_DECIM_DEF   = 10;
    localparam int ACC_W            = CORDIC_WIDTH_DEF + LOG2_DECIM_DEF;

    // Summing 2^log2 samples of w bits grows the value by exactly log2 bits.
    function automatic int acc_width(input int w, input int log2);
        return w + log2;
    endfunction

endpackage

// File: rtl/lockin_display_decimator_if.sv
// Sample stream in (from the CORDIC) and averaged stream out (to the visualizer).
interface lockin_display_decimator_if
    import lockin_pkg::*;
#(
    parameter int W = CORDIC_WIDTH_DEF
);
    logic         i_valid;
    logic [W-1:0] i_magnitude;
    logic [W-1:0] i_phase;
    logic         o_valid;
    logic [W-1:0] o_magnitude;
    logic [W-1:0] o_phase;

    modport master (
        output i_valid, i_magnitude, i_phase,
        input  o_valid, o_magnitude, o_phase
    );

    modport slave (
        input  i_valid, i_magnitude, i_phase,
        output o_valid, o_magnitude, o_phase
    );
endinterface

// File: rtl/lockin_boxcar_acc.sv
// Boxcar accumulator: sums samples and presents (acc + din) >> SHIFT for the closing sample.
module lockin_boxcar_acc
    import lockin_pkg::*;
#(
    parameter int WIDTH     = CORDIC_WIDTH_DEF,
    parameter int SHIFT     = LOG2_DECIM_DEF,
    parameter bit SIGNED_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             add,
    input  logic             clear,
    input  logic             dump,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = acc_width(WIDTH, SHIFT);

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] din_ext;
    logic [AW-1:0] sum;
    logic          unused_frac;

    generate
        if (SIGNED_EN) begin : g_sext
            assign din_ext = {{SHIFT{din[WIDTH-1]}}, din};
        end else begin : g_zext
            assign din_ext = {{SHIFT{1'b0}}, din};
        end
    endgenerate

    // Dropping the low SHIFT bits of a two's complement sum is a floor divide.
    assign sum         = acc_q + din_ext;
    assign dout        = sum[AW-1:SHIFT];
    assign unused_frac = ^sum[SHIFT-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clear || dump) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
endmodule

// File: rtl/lockin_display_decimator.sv
// Boxcar decimator feeding the VGA visualizer; one o_valid pulse per 2^LOG2_DECIM samples.
// Define LOCKIN_DEC_PEAK_HOLD_EN to report the window peak magnitude instead of the mean.
module lockin_display_decimator
    import lockin_pkg::*;
#(
    parameter int CORDIC_WIDTH = CORDIC_WIDTH_DEF,
    parameter int LOG2_DECIM   = LOG2_DECIM_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lockin_display_decimator_if.slave  bus,
    input  logic                       i_freeze,
    input  logic                       i_clear,
    output logic                       o_overrun
);
    logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic [CORDIC_WIDTH-1:0] mag_q, mag_d;
    logic [CORDIC_WIDTH-1:0] phs_q, phs_d;
    logic [CORDIC_WIDTH-1:0] mag_win, phs_win;
    logic                    accept, win_end;

    // Clear takes priority, so a coincident sample is simply not accepted.
    assign accept  = bus.i_valid && !i_clear;
    assign win_end = accept && (cnt_q == '1);

    lockin_boxcar_acc #(
        .WIDTH     (CORDIC_WIDTH),
        .SHIFT     (LOG2_DECIM),
        .SIGNED_EN (1'b1)
    ) u_phs_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .add   (accept),
        .clear (i_clear),
        .dump  (win_end),
        .din   (bus.i_phase),
        .dout  (phs_win)
    );

`ifdef LOCKIN_DEC_PEAK_HOLD_EN
    logic [CORDIC_WIDTH-1:0] max_q, max_d;

    always_comb begin
        mag_win = (bus.i_magnitude > max_q) ? bus.i_magnitude : max_q;
        max_d   = max_q;
        if (i_clear || win_end) begin
            max_d = '0;
        end else if (accept) begin
            max_d = mag_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end
`else
    lockin_boxcar_acc #(
        .WIDTH     (CORDIC_WIDTH),
        .SHIFT     (LOG2_DECIM),
        .SIGNED_EN (1'b0)
    ) u_mag_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .add   (accept),
        .clear (i_clear),
        .dump  (win_end),
        .din   (bus.i_magnitude),
        .dout  (mag_win)
    );
`endif

    always_comb begin
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        mag_d     = mag_q;
        phs_d     = phs_q;
        if (i_clear) begin
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + LOG2_DECIM'(1);
            if (win_end) begin
                // A frozen window is consumed but never shown.
                if (i_freeze) begin
                    overrun_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    mag_d   = mag_win;
                    phs_d   = phs_win;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            mag_q     <= '0;
            phs_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            mag_q     <= mag_d;
            phs_q     <= phs_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_magnitude = mag_q;
    assign bus.o_phase     = phs_q;
    assign o_overrun       = overrun_q;
endmodule
